stitch_wr_arbiter: RTL and testbench
====================================

STITCH_WR_ARBITER -- requirements
Module: stitch_wr_arbiter

Interface
REQ-001 Parameter CH_NUM, default 3, number of camera write channels (1..8).
REQ-002 Parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h10000000, base address added to every burst address.
REQ-003 Parameter C_M_AXI_BURST_LEN, default 16, beats per burst (1, 2, 4 ... 256).
REQ-004 Parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-005 Parameter C_M_AXI_DATA_WIDTH, default 128, AXI data width (32..1024, power of 2).
REQ-006 M_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-007 M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-008 ch_req  in  CH_NUM  channel i has at least BURST_LEN words ready.
REQ-009 ch_addr  in  CH_NUM*ADDR_W  per-channel burst offset address, channel i at slice i.
REQ-010 ch_rd_data  in  CH_NUM*DATA_W  per-channel first-word-fall-through FIFO data.
REQ-011 ch_rd_en  out  CH_NUM  one-hot FIFO pop strobe.
REQ-012 ch_done  out  CH_NUM  one-cycle pulse, burst of channel i completed.
REQ-013 ch_err  out  1  one-cycle pulse with ch_done when BRESP is non-OKAY.
REQ-014 M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out, AWREADY  in  AXI4 write address channel.
REQ-015 M_AXI_WDATA/WSTRB/WLAST/WVALID  out, WREADY  in  AXI4 write data channel.
REQ-016 M_AXI_BRESP/BVALID  in, BREADY  out  AXI4 write response channel.

Function
REQ-017 FSM states IDLE, AW, W, B; one burst outstanding at a time.
REQ-018 IDLE: if any ch_req bit set, grant the first requester after the last-served index (round-robin, wrapping CH_NUM-1 to 0), latch grant and ch_addr, enter AW next cycle.
REQ-019 AW: AWVALID=1; AWADDR=BASE+latched ch_addr; AWLEN=BURST_LEN-1; AWSIZE=log2(DATA_W/8); AWBURST=2'b01; AWID=0; fields stable until AWREADY; on handshake enter W.
REQ-020 W: WVALID=1, WDATA=ch_rd_data of granted channel, WSTRB all ones; ch_rd_en[grant]=WVALID&WREADY, combinational.
REQ-021 Beat counter, width clog2(BURST_LEN)+1, increments per W handshake; WLAST=1 only when counter equals BURST_LEN-1; last handshake enters B.
REQ-022 B: BREADY=1; on BVALID: ch_done[grant] pulses in the following cycle, ch_err pulses with it if BRESP!=2'b00, last-served index updates to grant, state returns to IDLE.
REQ-023 Latency: ch_req high in IDLE -> AWVALID high exactly 1 cycle later.
REQ-024 ch_req changes after grant are ignored until IDLE; ch_addr is sampled only at grant.
REQ-025 WREADY deasserted mid-burst: WDATA/WLAST hold, no pop, counter holds.
REQ-026 BURST_LEN=1: first beat asserts WLAST.
REQ-027 No AXI output changes without a preceding handshake while its VALID is high.

Reset
REQ-028 On M_AXI_ARESETN low, asynchronously: state IDLE, all VALID/READY, ch_rd_en, ch_done, ch_err, WLAST = 0, AWADDR/WDATA regs = 0, counter 0, last-served index CH_NUM-1 (channel 0 wins first).
REQ-029 Reset mid-burst abandons the burst; no ch_done issued for it.

Structure
REQ-030 Package stitch_axi_pkg holds the FSM state enum, AXI BURST_INCR and RESP_OKAY constants.
REQ-031 Sub-module rr_arbiter (CH_NUM-wide request, last-index in, one-hot grant and index out, combinational) is instantiated once.

Verification
REQ-032 ch_req=3'b010, ch_addr[1]=0x100, slave always ready -> AWADDR 0x10000100, AWLEN 15, AWSIZE 4, 16 beats, WLAST on beat 16 only, 16 ch_rd_en[1] pulses, ch_done=3'b010 once.
REQ-033 ch_req=3'b111 held for 4 bursts from reset -> grant order 0,1,2,0.
REQ-034 WREADY toggling 1-0-1-0 -> WDATA sequence equals FIFO order, exactly 16 pops, WLAST with 16th accepted beat.
REQ-035 AWREADY low 10 cycles -> AWVALID and AWADDR stable all 10 cycles, no W activity.
REQ-036 BRESP=2'b10 on channel 2 burst -> ch_done[2] and ch_err pulse together for one cycle.
REQ-037 Reset asserted at beat 7 then released with ch_req=3'b110 -> all outputs 0 during reset, no ch_done, first new grant channel 1.

Source files
------------

// File: rtl/stitch_axi_pkg.sv
// Shared FSM state type and AXI4 encodings for the stitch write path.
// No logic; types and constants only.
// Not applicable: holds no flow control.
package stitch_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester after last_idx, wrapping N-1 to 0.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter
    import stitch_axi_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    always_comb begin
        logic [IW-1:0] k_idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        k_idx     = '0;
        // Scan offsets 1..N so last_idx itself is considered last.
        for (int off = 1; off <= N; off++) begin
            k_idx = IW'((int'(last_idx) + off) % N);
            if (!grant_vld && req[k_idx]) begin
                grant_vld    = 1'b1;
                grant_idx    = k_idx;
                grant[k_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stitch_wr_arbiter.sv
// Arbitrates camera FIFO channels onto one AXI4 write master, one burst at a time.
// Latency: AWVALID one cycle after a request is seen in IDLE; ch_done one cycle after B.
// Backpressure: AW/W/B hold until handshake; FIFO pops only on accepted W beats.
module stitch_wr_arbiter
    import stitch_axi_pkg::*;
#(
    parameter int          CH_NUM                     = 3,
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter int          C_M_AXI_BURST_LEN          = 16,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 128
) (
    input  logic                                 M_AXI_ACLK,
    input  logic                                 M_AXI_ARESETN,

    input  logic [CH_NUM-1:0]                    ch_req,
    input  logic [CH_NUM*C_M_AXI_ADDR_WIDTH-1:0] ch_addr,
    input  logic [CH_NUM*C_M_AXI_DATA_WIDTH-1:0] ch_rd_data,
    output logic [CH_NUM-1:0]                    ch_rd_en,
    output logic [CH_NUM-1:0]                    ch_done,
    output logic                                 ch_err,

    output logic [0:0]                           M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [7:0]                           M_AXI_AWLEN,
    output logic [2:0]                           M_AXI_AWSIZE,
    output logic [1:0]                           M_AXI_AWBURST,
    output logic                                 M_AXI_AWVALID,
    input  logic                                 M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                                 M_AXI_WLAST,
    output logic                                 M_AXI_WVALID,
    input  logic                                 M_AXI_WREADY,

    input  logic [1:0]                           M_AXI_BRESP,
    input  logic                                 M_AXI_BVALID,
    output logic                                 M_AXI_BREADY
);

    localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int IW     = idx_width(CH_NUM);
    localparam int CW     = $clog2(C_M_AXI_BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(C_M_AXI_BURST_LEN - 1);

    wr_state_t           state;
    logic [IW-1:0]       last_idx;
    logic [IW-1:0]       grant_idx;
    logic [CH_NUM-1:0]   grant_oh;
    logic [CW-1:0]       beat_cnt;
    logic [ADDR_W-1:0]   aw_addr;
    logic                aw_vld;
    logic                w_vld;
    logic                b_rdy;

    logic [CH_NUM-1:0]   arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_vld;
    logic                w_hs;
    logic                w_last;

    rr_arbiter #(
        .N  (CH_NUM),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (ch_req),
        .last_idx  (last_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign w_hs   = w_vld && M_AXI_WREADY;
    assign w_last = w_vld && (beat_cnt == LAST_BEAT);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state     <= ST_IDLE;
            last_idx  <= IW'(CH_NUM - 1);
            grant_idx <= '0;
            grant_oh  <= '0;
            beat_cnt  <= '0;
            aw_addr   <= '0;
            aw_vld    <= 1'b0;
            w_vld     <= 1'b0;
            b_rdy     <= 1'b0;
            ch_done   <= '0;
            ch_err    <= 1'b0;
        end else begin
            ch_done <= '0;
            ch_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_grant;
                        aw_addr   <= ADDR_W'(C_M_TARGET_SLAVE_BASE_ADDR)
                                     + ch_addr[arb_idx*ADDR_W +: ADDR_W];
                        aw_vld    <= 1'b1;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (M_AXI_AWREADY) begin
                        aw_vld   <= 1'b0;
                        w_vld    <= 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            w_vld <= 1'b0;
                            b_rdy <= 1'b1;
                            state <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (M_AXI_BVALID) begin
                        b_rdy    <= 1'b0;
                        ch_done  <= grant_oh;
                        ch_err   <= (M_AXI_BRESP != RESP_OKAY);
                        last_idx <= grant_idx;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FWFT FIFOs present the head word directly, so data and pop are combinational.
    assign ch_rd_en      = w_hs ? grant_oh : '0;
    assign M_AXI_WDATA   = w_vld ? ch_rd_data[grant_idx*DATA_W +: DATA_W] : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last;
    assign M_AXI_WVALID  = w_vld;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = aw_addr;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DATA_W / 8));
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = aw_vld;

    assign M_AXI_BREADY  = b_rdy;

endmodule

// File: tb/tb_stitch_wr_arbiter.sv
// Directed vector bench for stitch_wr_arbiter with a FWFT FIFO model per channel.
module tb_stitch_wr_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int LEN = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      ch_req;
    logic [N*AW-1:0]   ch_addr;
    logic [N*DW-1:0]   ch_rd_data;
    logic [N-1:0]      ch_rd_en;
    logic [N-1:0]      ch_done;
    logic              ch_err;
    logic [0:0]        awid;
    logic [AW-1:0]     awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    always #5 clk = ~clk;

    stitch_wr_arbiter #(
        .CH_NUM                     (N),
        .C_M_TARGET_SLAVE_BASE_ADDR (32'h10000000),
        .C_M_AXI_BURST_LEN          (LEN),
        .C_M_AXI_ADDR_WIDTH         (AW),
        .C_M_AXI_DATA_WIDTH         (DW)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .ch_req        (ch_req),
        .ch_addr       (ch_addr),
        .ch_rd_data    (ch_rd_data),
        .ch_rd_en      (ch_rd_en),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .M_AXI_AWID    (awid),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int ch, input int p);
        return {32'hCAFE0000 + 32'(ch), 64'h0, 32'(p)};
    endfunction

    // FWFT FIFO model: head word advances on each pop strobe.
    int fifo_ptr [N] = '{0, 0, 0};
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (ch_rd_en[i]) fifo_ptr[i] <= fifo_ptr[i] + 1;

    always_comb begin
        ch_rd_data = '0;
        for (int i = 0; i < N; i++)
            ch_rd_data[i*DW +: DW] = mkdata(i, fifo_ptr[i]);
    end

    int pop_cnt [N] = '{0, 0, 0};
    int done_cnt = 0;
    always @(posedge clk) begin
        if (|ch_done) done_cnt++;
        for (int i = 0; i < N; i++)
            if (ch_rd_en[i]) pop_cnt[i]++;
    end

    typedef struct {
        bit        rst;
        logic [2:0] req;
        int        aw_wait;
        bit        wtog;
        logic [1:0] resp;
        int        g;
        logic [31:0] exp_addr;
        bit        exp_err;
    } vec_t;

    vec_t vecs [7];
    int   exp_ptr [N] = '{0, 0, 0};

    task automatic check_quiet(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"},  wvalid,  0);
        chk({tag, "_bready"},  bready,  0);
        chk({tag, "_wlast"},   wlast,   0);
        chk({tag, "_rd_en"},   ch_rd_en, 0);
        chk({tag, "_done"},    ch_done, 0);
        chk({tag, "_err"},     ch_err,  0);
        chk({tag, "_awaddr"},  awaddr,  0);
        chk({tag, "_wdata"},   wdata,   0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ch_req = '0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        #1 check_quiet("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int p_before [N];
        int d_before;
        int beats;
        int cyc;
        if (v.rst) do_reset();
        for (int i = 0; i < N; i++) p_before[i] = pop_cnt[i];
        d_before = done_cnt;

        @(negedge clk);
        ch_req = v.req;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_aw_latency", id), awvalid, 1);
        chk($sformatf("v%0d_awaddr", id), awaddr, v.exp_addr);
        chk($sformatf("v%0d_awlen", id), awlen, 15);
        chk($sformatf("v%0d_awsize", id), awsize, 4);
        chk($sformatf("v%0d_awburst", id), awburst, 1);
        chk($sformatf("v%0d_awid", id), awid, 0);
        chk($sformatf("v%0d_wstrb", id), wstrb, {(DW/8){1'b1}});
        // Requests after the grant must not disturb the burst.
        ch_req = '0;

        for (int c = 0; c < v.aw_wait; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_aw_hold_vld", id), awvalid, 1);
            chk($sformatf("v%0d_aw_hold_addr", id), awaddr, v.exp_addr);
            chk($sformatf("v%0d_aw_no_w", id), wvalid, 0);
        end
        awready = 1'b1;

        beats = 0;
        cyc = 0;
        while (beats < LEN && cyc < 200) begin
            @(negedge clk);
            awready = 1'b0;
            wready = v.wtog ? (cyc % 2 == 0) : 1'b1;
            #1;
            cyc++;
            if (wvalid) begin
                chk($sformatf("v%0d_wdata_b%0d", id, beats), wdata, mkdata(v.g, exp_ptr[v.g] + beats));
                chk($sformatf("v%0d_wlast_b%0d", id, beats), wlast, (beats == LEN - 1));
                chk($sformatf("v%0d_rd_en_b%0d", id, beats), ch_rd_en, wready ? (3'b001 << v.g) : 3'b000);
                if (wready) beats++;
            end else begin
                chk($sformatf("v%0d_rd_en_idle", id), ch_rd_en, 0);
            end
        end
        chk($sformatf("v%0d_beats", id), beats, LEN);
        exp_ptr[v.g] += LEN;

        @(negedge clk);
        wready = 1'b0;
        #1;
        chk($sformatf("v%0d_w_done", id), wvalid, 0);
        chk($sformatf("v%0d_bready", id), bready, 1);
        bvalid = 1'b1;
        bresp  = v.resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        #1;
        chk($sformatf("v%0d_done", id), ch_done, 3'b001 << v.g);
        chk($sformatf("v%0d_err", id), ch_err, v.exp_err);
        chk($sformatf("v%0d_bready_low", id), bready, 0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse", id), ch_done, 0);
        chk($sformatf("v%0d_err_pulse", id), ch_err, 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("v%0d_pops_ch%0d", id, i), pop_cnt[i] - p_before[i], (i == v.g) ? LEN : 0);
        chk($sformatf("v%0d_done_count", id), done_cnt - d_before, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d_before;
        int cyc;

        vecs[0] = '{1'b1, 3'b010,  0, 1'b0, 2'b00, 1, 32'h10000100, 1'b0};
        vecs[1] = '{1'b1, 3'b111,  0, 1'b0, 2'b00, 0, 32'h10000040, 1'b0};
        vecs[2] = '{1'b0, 3'b111,  0, 1'b1, 2'b00, 1, 32'h10000100, 1'b0};
        vecs[3] = '{1'b0, 3'b111,  0, 1'b0, 2'b10, 2, 32'h10000280, 1'b1};
        vecs[4] = '{1'b0, 3'b111, 10, 1'b0, 2'b00, 0, 32'h10000040, 1'b0};
        vecs[5] = '{1'b0, 3'b101,  0, 1'b0, 2'b01, 2, 32'h10000280, 1'b1};
        vecs[6] = '{1'b0, 3'b001,  0, 1'b1, 2'b00, 0, 32'h10000040, 1'b0};

        rst_n = 1'b0; ch_req = '0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ch_addr = {32'h00000280, 32'h00000100, 32'h00000040};
        #1 check_quiet("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a channel 0 burst after 7 accepted beats.
        @(negedge clk);
        ch_req = 3'b001;
        @(negedge clk);
        #1 chk("mid_rst_awvalid", awvalid, 1);
        ch_req = '0;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready = 1'b1;
        p0 = pop_cnt[0];
        cyc = 0;
        while (pop_cnt[0] - p0 < 7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        wready = 1'b0;
        ch_req = 3'b110;
        d_before = done_cnt;
        #1;
        chk("mid_rst_pops", pop_cnt[0] - p0, 7);
        check_quiet("mid_rst");
        @(negedge clk);
        #1 check_quiet("mid_rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_awvalid", awvalid, 1);
        chk("post_rst_grant_ch1", awaddr, 32'h10000100);
        chk("post_rst_wvalid", wvalid, 0);
        @(negedge clk);
        #1 chk("post_rst_no_done", done_cnt - d_before, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
